tnn_accumulator: RTL
====================

TNN_ACCUMULATOR -- requirements
Module: tnn_accumulator

Interface
REQ-001 SHALL have parameter FEATURE_WIDTH, default 32, signed width of each lane input and of out_data.
REQ-002 SHALL have parameter LANES, default 9, number of select-unit products summed per beat.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, internal signed accumulator width.
REQ-004 SHALL have parameter LEN_WIDTH, default 12, width of cfg_len.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, synchronous flush of all in-flight state.
REQ-008 SHALL have port cfg_len, input, LEN_WIDTH, beats per output result.
REQ-009 SHALL have port in_valid, input, 1, in_data valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts a beat.
REQ-011 SHALL have port in_data, input, LANES*FEATURE_WIDTH, packed signed lane products, lane 0 in LSBs.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port out_data, output, FEATURE_WIDTH, signed saturated result.
REQ-015 SHALL have port out_sat, output, 1, out_data was clipped.

Function
REQ-016 Beat accepted SHALL mean in_valid && in_ready at a rising clk edge.
REQ-017 States SHALL be IDLE, ACC, DRAIN, HOLD; in_ready=1 only in IDLE and ACC; out_valid=1 only in HOLD.
REQ-018 cfg_len SHALL be sampled on the first beat accepted in IDLE; value 0 treated as 1; changes mid-result ignored.
REQ-019 Stage 1 SHALL register the sum of all LANES sign-extended to ACC_WIDTH (1-cycle latency).
REQ-020 Stage 2 SHALL add stage-1 sum into accumulator; the first beat of a result overwrites (not adds to) the accumulator.
REQ-021 Beat counter SHALL count accepted beats; IDLE->ACC on first beat unless it is also last; ACC/IDLE->DRAIN on accepting beat number len.
REQ-022 DRAIN SHALL last exactly one cycle, then HOLD; out_valid SHALL rise 2 cycles after the last beat's accept edge.
REQ-023 On HOLD entry out_data SHALL be accumulator clipped to [-2^(FEATURE_WIDTH-1), 2^(FEATURE_WIDTH-1)-1]; out_sat=1 iff clipped.
REQ-024 out_data/out_sat SHALL stay stable while out_valid && !out_ready.
REQ-025 HOLD->IDLE on out_valid && out_ready; in_ready SHALL be 1 the following cycle; no beat accepted in the handshake cycle.
REQ-026 Accumulator SHALL wrap (two's complement) only beyond ACC_WIDTH; no internal saturation.
REQ-027 clear SHALL override all other inputs: next state IDLE, counter/accumulator zeroed, out_valid=0, in-flight beats discarded.
REQ-028 in_valid low in ACC SHALL hold state and partial sum indefinitely.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, counter 0, accumulator 0, stage-1 register 0, out_valid 0, out_data 0, out_sat 0.
REQ-030 After rst_n release, in_ready SHALL be 1 in the first cycle.
REQ-031 Reset mid-result SHALL discard the partial sum; no output produced for it.

Verification
REQ-032 cfg_len=3, beats of all lanes =1,2,3 back-to-back -> out_data=54, out_sat=0, out_valid 2 cycles after beat 3.
REQ-033 cfg_len=0, one beat lanes=-5 -> treated as len 1, out_data=-45.
REQ-034 cfg_len=2, lanes=0x7FFFFFFF both beats -> out_data=0x7FFFFFFF, out_sat=1; mirror with 0x80000000 -> 0x80000000, out_sat=1.
REQ-035 Result in HOLD, out_ready low 5 cycles then high -> out_data stable, in_ready=0 throughout, in_ready=1 the cycle after handshake.
REQ-036 cfg_len=4, 2 beats, clear pulse, then 4 beats of lanes=1 -> out_data=36 (no residue).
REQ-037 cfg_len=4, gaps of 3 idle cycles between beats with lanes=-1 -> out_data=-36; rst_n pulse after beat 2 of a second result -> all outputs 0, no output.

Source files
------------

// File: rtl/tnn_accumulator.sv
// tnn_accumulator: sums LANES signed products per beat over cfg_len beats and emits a saturated result
module tnn_accumulator #(
    parameter int FEATURE_WIDTH = 32,
    parameter int LANES         = 9,
    parameter int ACC_WIDTH     = 48,
    parameter int LEN_WIDTH     = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*FEATURE_WIDTH-1:0]   in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [FEATURE_WIDTH-1:0]         out_data,
    output logic                             out_sat
);
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;
    state_t                       state;
    logic [LEN_WIDTH-1:0]         cnt, len_q, len_cur, cnt_nxt;
    logic [ACC_WIDTH-1:0]         lane_sum, s1_sum, acc, acc_nxt;
    logic [ACC_WIDTH-FEATURE_WIDTH:0] hi;
    logic [FEATURE_WIDTH-1:0]     clip;
    logic                         s1_valid, s1_first, accept, last, sat;

    assign in_ready = state == IDLE || state == ACC;
    assign accept   = in_valid && in_ready;
    assign len_cur  = state == IDLE ? (cfg_len == '0 ? LEN_WIDTH'(1) : cfg_len) : len_q;
    assign cnt_nxt  = cnt + LEN_WIDTH'(1);
    assign last     = cnt_nxt == len_cur;
    assign acc_nxt  = !s1_valid ? acc : s1_first ? s1_sum : acc + s1_sum;
    assign hi       = acc_nxt[ACC_WIDTH-1:FEATURE_WIDTH-1];
    assign sat      = !(&hi || ~|hi);
    assign clip     = sat ? {acc_nxt[ACC_WIDTH-1], {(FEATURE_WIDTH-1){~acc_nxt[ACC_WIDTH-1]}}}
                          : acc_nxt[FEATURE_WIDTH-1:0];

    // sign-extend every lane to the accumulator width and add them up
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + {{(ACC_WIDTH-FEATURE_WIDTH){in_data[i*FEATURE_WIDTH+FEATURE_WIDTH-1]}},
                                   in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH]};
    end

    // stage 1 registers the beat sum, stage 2 folds it into the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            acc      <= '0;
        end else if (clear) begin
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            acc      <= '0;
        end else begin
            s1_sum   <= accept ? lane_sum : s1_sum;
            s1_valid <= accept;
            s1_first <= accept && state == IDLE;
            acc      <= acc_nxt;
        end
    end

    // beat counting, result framing and the registered output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    len_q <= len_cur;
                    cnt   <= cnt_nxt;
                    state <= last ? DRAIN : ACC;
                end
                ACC: if (accept) begin
                    cnt   <= cnt_nxt;
                    state <= last ? DRAIN : ACC;
                end
                DRAIN: begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    out_data  <= clip;
                    out_sat   <= sat;
                end
                HOLD: if (out_ready) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
